arbitro_memoria: RTL
====================

# arbitro_memoria

Single-port memory arbiter for the multicycle RISC-V core. It shares one memory between the instruction-fetch requester (driven by the control state machine alongside PC/IR writes) and the load/store data requester. Each transaction is sequenced through a fixed address/wait/complete pattern that respects the memory's read latency. Each requester gets a one-cycle completion pulse with registered read data.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- MEM_LAT, 1, memory read latency in cycles (≥1): read data valid MEM_LAT cycles after address is first presented
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- I_REQ  input  1  fetch request; held high until I_DONE
- I_ADDR  input  ADDR_W  fetch address
- I_RDATA  output  DATA_W  registered fetched instruction word
- I_DONE  output  1  one-cycle fetch completion pulse
- D_REQ  input  1  data request; held high until D_DONE
- D_WE  input  1  1 = store, 0 = load
- D_ADDR  input  ADDR_W  data address
- D_WDATA  input  DATA_W  store data
- D_RDATA  output  DATA_W  registered load data
- D_DONE  output  1  one-cycle data completion pulse
- MEM_ADDR  output  ADDR_W  memory address
- MEM_WDATA  output  DATA_W  memory write data
- MEM_WE  output  1  memory write enable, active high
- MEM_RDATA  input  DATA_W  memory read data
- BUSY  output  1  high in every state except IDLE

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- **IDLE:**
  - If no REQ is high, stay in IDLE.
  - Otherwise arbitrate and register the winner (owner, addr, wdata, we; fetch always has we=0).
  - Go to ACCESS.
- **Arbitration (default round-robin):**
  - Only one REQ high: that requester wins.
  - Both high: the requester that is not last_owner wins.
  - last_owner updates on each grant and resets to DATA, so fetch wins the first conflict after reset.
- **ACCESS:**
  - MEM_ADDR and MEM_WDATA are driven from the latched registers.
  - MEM_WE = latched we, for exactly this cycle.
  - Store: go to DONE.
  - Load/fetch: load the latency counter with MEM_LAT and go to WAIT.
- **WAIT:**
  - MEM_ADDR is held at the latched address; MEM_WE = 0.
  - The counter decrements each cycle.
  - On the last WAIT cycle (counter = 1), capture MEM_RDATA into the owner's RDATA register, then go to DONE.
- **DONE:**
  - Pulse the owner's DONE for one cycle; the other DONE stays 0.
  - Go to IDLE.
- **Bus outside ACCESS/WAIT:** MEM_ADDR = 0, MEM_WDATA = 0, MEM_WE = 0.
- **RDATA registers:**
  - They change only on capture; the non-owner's RDATA is never modified.
  - Stores leave D_RDATA unchanged.
- **REQ deasserted mid-transaction:** ignored; the transaction completes and DONE still pulses.
- **REQ still high in the IDLE cycle after DONE:** treated as a new request (back-to-back allowed).
- **Reset (including mid-transaction):**
  - State returns to IDLE and any pending DONE is not issued.
  - MEM_WE = 0 from the reset cycle on.
  - last_owner returns to DATA.

## Timing
- Reset values:
  - MEM_ADDR = 0, MEM_WDATA = 0, MEM_WE = 0.
  - I_RDATA = 0, D_RDATA = 0.
  - I_DONE = 0, D_DONE = 0, BUSY = 0.
- Request sampled in IDLE at cycle t.
- ACCESS occupies cycle t+1.
- Read/fetch:
  - WAIT occupies cycles t+2 … t+1+MEM_LAT.
  - DONE in cycle t+2+MEM_LAT.
  - Next grant possible at t+3+MEM_LAT.
- Store: DONE in cycle t+2; next grant at t+3.
- RDATA is valid from the DONE cycle until the next capture for that requester.
- DONE, BUSY and MEM_* are registered-state decodes; there is no combinational path from REQ to any output.

## Configuration
- ARB_MEM_DATA_PRIO_EN:
  - Defined: fixed priority; D_REQ always wins a conflict over I_REQ, and last_owner is unused.
  - Undefined: round-robin as specified above.

## Test plan
- **Single fetch, MEM_LAT=1:**
  - Stimulus: I_REQ=1, I_ADDR=0x10, memory returns 0x00A00093.
  - Response: MEM_ADDR=0x10 in cycles t+1..t+2; I_DONE pulses at t+3 with I_RDATA=0x00A00093; D_DONE stays 0.
- **Store:**
  - Stimulus: D_REQ=1, D_WE=1, D_ADDR=0x80, D_WDATA=0xDEADBEEF.
  - Response: MEM_WE=1 only in cycle t+1 with those values; D_DONE at t+2; D_RDATA unchanged.
- **Simultaneous I_REQ and D_REQ held, round-robin build:**
  - Response: grants alternate fetch, data, fetch, data.
  - With ARB_MEM_DATA_PRIO_EN defined: data is granted every time while D_REQ is held.
- **MEM_LAT=3 load:**
  - Stimulus: D_ADDR=0x40, memory returns 0x1234.
  - Response: WAIT lasts 3 cycles; D_DONE at t+5 with D_RDATA=0x1234; BUSY high t+1..t+5.
- **Reset mid-WAIT:**
  - Stimulus: RST=1 for one cycle during WAIT.
  - Response: next cycle IDLE, BUSY=0, no DONE pulse, MEM_ADDR=0, RDATA registers =0.
- **REQ dropped during WAIT:**
  - Response: transaction still completes and DONE pulses once.
  - Afterwards the block stays in IDLE.

Source files
------------

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: single-port memory arbiter shared by the instruction-fetch
// and load/store requesters of the multicycle core. Each grant runs through
// IDLE -> ACCESS -> (WAIT x MEM_LAT for reads) -> DONE.
// Optional build macro ARB_MEM_DATA_PRIO_EN: when defined, data always wins a
// conflict (fixed priority); when undefined, conflicts are round-robin.
module arbitro_memoria #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic [DATA_W-1:0] I_RDATA,
    output logic              I_DONE,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_DONE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              BUSY
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                grant_data;
`ifndef ARB_MEM_DATA_PRIO_EN
    logic                last_owner_q, last_owner_d;
`endif

    // Arbitration: a lone requester wins; on conflict either data has fixed
    // priority or the requester that was not granted last time wins.
    always_comb begin
`ifdef ARB_MEM_DATA_PRIO_EN
        grant_data = D_REQ;
`else
        grant_data = D_REQ && (!I_REQ || (last_owner_q == OWN_FETCH));
`endif
    end

    // Control and read-data registers; reset drops any transaction in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
`ifndef ARB_MEM_DATA_PRIO_EN
            last_owner_q <= OWN_DATA;
`endif
        end else begin
            state_q      <= state_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
`ifndef ARB_MEM_DATA_PRIO_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // Latched transaction fields; only meaningful outside IDLE, so no reset.
    always_ff @(posedge CLK) begin
        owner_q <= owner_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        we_q    <= we_d;
        cnt_q   <= cnt_d;
    end

    // Next-state logic: grant in IDLE, count latency in WAIT, capture read data.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifndef ARB_MEM_DATA_PRIO_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (I_REQ || D_REQ) begin
                    owner_d = grant_data ? OWN_DATA : OWN_FETCH;
                    addr_d  = grant_data ? D_ADDR : I_ADDR;
                    wdata_d = grant_data ? D_WDATA : '0;
                    we_d    = grant_data && D_WE;
`ifndef ARB_MEM_DATA_PRIO_EN
                    last_owner_d = grant_data ? OWN_DATA : OWN_FETCH;
`endif
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = CNT_W'(MEM_LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (owner_q == OWN_DATA) begin
                        d_rdata_d = MEM_RDATA;
                    end else begin
                        i_rdata_d = MEM_RDATA;
                    end
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state; the write strobe is also
    // suppressed during a reset cycle.
    always_comb begin
        BUSY      = (state_q != ST_IDLE);
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        MEM_WE    = 1'b0;
        I_DONE    = 1'b0;
        D_DONE    = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                MEM_ADDR  = addr_q;
                MEM_WDATA = wdata_q;
                MEM_WE    = we_q && !RST;
            end
            ST_WAIT: begin
                MEM_ADDR  = addr_q;
                MEM_WDATA = wdata_q;
            end
            ST_DONE: begin
                I_DONE = (owner_q == OWN_FETCH);
                D_DONE = (owner_q == OWN_DATA);
            end
            default: begin
            end
        endcase
    end

    assign I_RDATA = i_rdata_q;
    assign D_RDATA = d_rdata_q;

endmodule
